// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID-stage pipeline control: opcodes, ALUOp codes,
// FSM state encoding and the registered control bundle.
package pipe_ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int AOP_W = 2;
  localparam logic [AOP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [AOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [AOP_W-1:0] ALUOP_R   = 2'b10;
  localparam logic [AOP_W-1:0] ALUOP_I   = 2'b11;

  typedef enum logic [1:0] {RUN, STALL_LU, FLUSH, MULDIV} state_t;

  typedef struct packed {
    logic             branch;
    logic             jump;
    logic             alusrc;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             muldiv;
    logic [AOP_W-1:0] aluop;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus rs1/rs2-used flags.
// M-extension recognition is compiled in with DECODER_MULDIV_EN.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl,
  output logic       o_rs1_used,
  output logic       o_rs2_used
);
  always_comb begin
    o_ctrl     = '0;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    case (i_opcode)
      OP_LOAD: begin
        o_ctrl.alusrc = 1'b1; o_ctrl.regwrite = 1'b1;
        o_ctrl.memread = 1'b1; o_ctrl.memtoreg = 1'b1;
        o_ctrl.aluop = ALUOP_MEM; o_rs1_used = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alusrc = 1'b1; o_ctrl.memwrite = 1'b1; o_ctrl.aluop = ALUOP_MEM;
        o_rs1_used = 1'b1; o_rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1; o_ctrl.aluop = ALUOP_BR;
        o_rs1_used = 1'b1; o_rs2_used = 1'b1;
      end
      OP_RTYPE: begin
        o_ctrl.regwrite = 1'b1; o_ctrl.aluop = ALUOP_R;
        o_rs1_used = 1'b1; o_rs2_used = 1'b1;
`ifdef DECODER_MULDIV_EN
        o_ctrl.muldiv = (i_funct7 == F7_MULDIV);
`endif
      end
      OP_IALU: begin
        o_ctrl.alusrc = 1'b1; o_ctrl.regwrite = 1'b1; o_ctrl.aluop = ALUOP_I;
        o_rs1_used = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.jump = 1'b1; o_ctrl.regwrite = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.jump = 1'b1; o_ctrl.regwrite = 1'b1; o_ctrl.alusrc = 1'b1;
        o_rs1_used = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef DECODER_MULDIV_EN
  logic w_unused_f7;
  assign w_unused_f7 = ^i_funct7;
`endif
endmodule

// File: rtl/id_ex_ctrl_unit.sv
// ID-stage control: decode into ID/EX, load-use stall, taken-branch/jump flush.
// Optional DECODER_MULDIV_EN holds a multi-cycle M-extension op in EX.
module id_ex_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int REG_AW       = 5,
  parameter int ALUOP_W      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int MULDIV_LAT   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  input  logic               branch_taken_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               ex_valid_o,
  output logic               ex_branch_o,
  output logic               ex_jump_o,
  output logic               ex_alusrc_o,
  output logic               ex_regwrite_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               ex_memtoreg_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic [REG_AW-1:0]  ex_rd_o,
  output logic               ex_muldiv_o
);
  localparam int CNT_MAX = (FLUSH_CYCLES > MULDIV_LAT) ? FLUSH_CYCLES : MULDIV_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ctrl_t             w_dec, r_ctrl;
  logic              w_rs1_used, w_rs2_used;
  logic              r_valid;
  logic [REG_AW-1:0] r_rd, w_rs1, w_rs2, w_rd;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_hazard, w_flush_evt, w_hold;

  ctrl_decode u_dec (
    .i_opcode   (instr_i[6:0]),
    .i_funct7   (instr_i[31:25]),
    .o_ctrl     (w_dec),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign w_rd  = instr_i[7  +: REG_AW];
  assign w_rs1 = instr_i[15 +: REG_AW];
  assign w_rs2 = instr_i[20 +: REG_AW];

  assign w_hazard = r_valid && r_ctrl.memread && (r_rd != '0) &&
                    ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));
  assign w_flush_evt = (r_ctrl.branch && branch_taken_i) || r_ctrl.jump;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      FLUSH: begin
        flush_o = 1'b1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= 1)  w_state_nxt = RUN;
      end
`ifdef DECODER_MULDIV_EN
      MULDIV: begin
        // EX keeps the M-op; any flush waits until the op has left EX
        stall_o = 1'b1;
        w_hold  = 1'b1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= 1)  w_state_nxt = RUN;
      end
`endif
      default: begin
        // STALL_LU runs the same checks: EX holds a bubble, so nothing fires
        w_state_nxt = RUN;
        if (w_flush_evt) begin
          flush_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (w_hazard) begin
          stall_o     = 1'b1;
          w_state_nxt = STALL_LU;
        end
`ifdef DECODER_MULDIV_EN
        else if (instr_valid_i && w_dec.muldiv && (MULDIV_LAT > 1)) begin
          w_state_nxt = MULDIV;
          w_cnt_nxt   = CNT_W'(MULDIV_LAT - 1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!w_hold) begin
        if (!instr_valid_i || stall_o || flush_o) begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_rd    <= '0;
        end else begin
          r_valid <= 1'b1;
          r_ctrl  <= w_dec;
          r_rd    <= w_rd;
        end
      end
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_branch_o   = r_ctrl.branch;
  assign ex_jump_o     = r_ctrl.jump;
  assign ex_alusrc_o   = r_ctrl.alusrc;
  assign ex_regwrite_o = r_ctrl.regwrite;
  assign ex_memread_o  = r_ctrl.memread;
  assign ex_memwrite_o = r_ctrl.memwrite;
  assign ex_memtoreg_o = r_ctrl.memtoreg;
  assign ex_aluop_o    = ALUOP_W'(r_ctrl.aluop);
  assign ex_rd_o       = r_rd;
  assign ex_muldiv_o   = r_ctrl.muldiv;

  logic w_unused;
  assign w_unused = ^instr_i;
endmodule

// File: tb/tb_id_ex_ctrl_unit.sv
// Directed bench for id_ex_ctrl_unit (FLUSH_CYCLES=2); the M-op section
// follows DECODER_MULDIV_EN.
module tb_id_ex_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid, taken;
  logic        stall, flush, ex_valid, ex_branch, ex_jump, ex_alusrc;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_muldiv;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rd;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW5    = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] ADD675 = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] LW0    = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] ADD601 = 32'h0010_0333; // add x6,x0,x1
  localparam logic [31:0] ADD611 = 32'h0010_8333; // add x6,x1,x1
  localparam logic [31:0] BEQ    = 32'h0020_8063; // beq x1,x2,0
  localparam logic [31:0] BNE    = 32'h0020_9063; // bne x1,x2,0
  localparam logic [31:0] JAL    = 32'h0000_00EF; // jal x1,0
  localparam logic [31:0] SW     = 32'h0050_A023; // sw x5,0(x1)
  localparam logic [31:0] MUL    = 32'h0231_00B3; // mul x1,x2,x3
  localparam logic [31:0] BADOP  = 32'h0000_007F;

  always #5 clk = ~clk;

  id_ex_ctrl_unit #(.FLUSH_CYCLES(2), .MULDIV_LAT(4)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(valid),
    .branch_taken_i(taken), .stall_o(stall), .flush_o(flush),
    .ex_valid_o(ex_valid), .ex_branch_o(ex_branch), .ex_jump_o(ex_jump),
    .ex_alusrc_o(ex_alusrc), .ex_regwrite_o(ex_regwrite), .ex_memread_o(ex_memread),
    .ex_memwrite_o(ex_memwrite), .ex_memtoreg_o(ex_memtoreg), .ex_aluop_o(ex_aluop),
    .ex_rd_o(ex_rd), .ex_muldiv_o(ex_muldiv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // set ID inputs just after an edge, then let combinational outputs settle
  task automatic drive(input logic [31:0] ins, input logic v, input logic tk);
    instr = ins; valid = v; taken = tk;
    #2;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; valid = 1'b0; taken = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", ex_valid, 0); chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);    chk("rst_ctrl", {ex_regwrite, ex_memread, ex_aluop, ex_rd}, 0);
    rst = 1'b0;

    drive(ADDI, 1, 0); edge1();
    chk("addi_valid", ex_valid, 1); chk("addi_aluop", ex_aluop, 2'b11);
    chk("addi_alusrc", ex_alusrc, 1); chk("addi_rd", ex_rd, 1);

    drive(LW5, 1, 0); chk("lw_nostall", stall, 0); edge1();
    chk("lw_ctrl", {ex_memread, ex_memtoreg, ex_regwrite, ex_alusrc}, 4'b1111);
    chk("lw_aluop", ex_aluop, 2'b00); chk("lw_rd", ex_rd, 5);

    drive(ADD675, 1, 0); chk("lu_stall", stall, 1); chk("lu_noflush", flush, 0); edge1();
    chk("lu_bubble", {ex_valid, ex_regwrite, ex_memread, ex_rd}, 0);
    drive(ADD675, 1, 0); chk("lu_release", stall, 0); edge1();
    chk("add_issue", {ex_valid, ex_regwrite, ex_alusrc}, 3'b110);
    chk("add_aluop", ex_aluop, 2'b10); chk("add_rd", ex_rd, 6);

    drive(LW0, 1, 0); edge1();
    chk("lw0_ex", {ex_valid, ex_memread, ex_rd}, {2'b11, 5'd0});
    drive(ADD601, 1, 0); chk("x0_nostall", stall, 0); edge1();
    chk("x0_add_issue", ex_valid, 1);

    // taken branch: two flush cycles, two bubbles
    drive(BEQ, 1, 0); edge1();
    chk("beq_ctrl", {ex_branch, ex_regwrite, ex_aluop}, 4'b1001);
    drive(ADDI, 1, 1); chk("br_flush1", flush, 1); chk("br_nostall", stall, 0); edge1();
    chk("br_bubble1", ex_valid, 0);
    drive(ADDI, 1, 0); chk("br_flush2", flush, 1); edge1();
    chk("br_bubble2", ex_valid, 0);
    drive(ADDI, 1, 0); chk("br_flush_end", flush, 0); edge1();
    chk("br_after", ex_valid, 1);

    drive(BEQ, 1, 0); edge1();
    drive(ADDI, 1, 0); chk("nt_noflush", flush, 0); edge1();
    chk("nt_issue", ex_valid, 1);

    // jal in EX while ID reads jal's destination: flush wins, no stall
    drive(JAL, 1, 0); edge1();
    chk("jal_ctrl", {ex_jump, ex_regwrite, ex_alusrc, ex_rd}, {3'b110, 5'd1});
    drive(ADD611, 1, 0); chk("jal_flush", flush, 1); chk("jal_nostall", stall, 0); edge1();
    chk("jal_bubble", ex_valid, 0);
    drive(ADD611, 1, 0); chk("jal_flush2", flush, 1); edge1();

    drive(SW, 1, 0); edge1();
    chk("sw_ctrl", {ex_memwrite, ex_regwrite, ex_alusrc, ex_aluop}, 5'b10100);
    drive(BNE, 1, 0); chk("sw_nostall", stall, 0); edge1();
    chk("bne_ctrl", {ex_branch, ex_regwrite, ex_aluop}, 4'b1001);

    drive(ADDI, 0, 0); chk("bne_nt_noflush", flush, 0); edge1();
    chk("invalid_bubble", {ex_valid, ex_alusrc, ex_aluop}, 0);
    drive(BADOP, 1, 0); edge1();
    chk("badop", {ex_valid, ex_branch, ex_jump, ex_alusrc, ex_regwrite,
                  ex_memread, ex_memwrite, ex_memtoreg, ex_aluop}, 10'b1000000000);

    drive(MUL, 1, 0); edge1();
    chk("mul_aluop", ex_aluop, 2'b10); chk("mul_valid", ex_valid, 1);
`ifdef DECODER_MULDIV_EN
    chk("mul_flag", ex_muldiv, 1);
    for (int i = 0; i < 3; i++) begin
      drive(ADDI, 1, 0); chk("md_stall", stall, 1); edge1();
      chk("md_hold", {ex_muldiv, ex_rd}, {1'b1, 5'd1});
    end
    drive(ADDI, 1, 0); chk("md_release", stall, 0); edge1();
    chk("md_next", {ex_muldiv, ex_aluop}, 3'b011);
`else
    chk("mul_flag", ex_muldiv, 0);
    drive(ADDI, 1, 0); chk("mul_nostall", stall, 0); edge1();
    chk("mul_next", ex_aluop, 2'b11);
`endif

    // reset in the middle of a flush sequence
    drive(BEQ, 1, 0); edge1();
    drive(ADDI, 1, 1); edge1();
    drive(ADDI, 1, 0); chk("pre_rst_flush", flush, 1);
    rst = 1'b1; #1;
    chk("midrst_flush", flush, 0); chk("midrst_stall", stall, 0);
    chk("midrst_ex", {ex_valid, ex_branch, ex_aluop, ex_rd}, 0);
    rst = 1'b0; #1;
    edge1();
    chk("post_rst_addi", {ex_valid, ex_alusrc, ex_aluop}, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
